graph_mem_arbiter: RTL and testbench

Shares the graph memory's three read ports among NUM_PROC traversal processors. The ports are the row-pointer port and data ports A and B.
- Round-robin arbitration, one port per request.
- Issues tagged addresses {proc_id, addr} to memory.
- Tracks the fixed BRAM read latency with its own tag pipeline; the memory's valid outputs are not used.
- Routes each returned word to the requesting processor's response lane.

---
 rtl/graph_mem_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_graph_mem_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/graph_mem_arbiter.sv
// Shares the graph memory's row-pointer port and data ports A/B among NUM_PROC processors.
// Each port has a tag pipeline that matches the BRAM latency and routes read data to the requester.
module graph_mem_arbiter #(
    parameter int unsigned NUM_PROC    = 4,
    parameter int unsigned PROC_BITS   = 2,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [NUM_PROC-1:0]       req_valid_in,
    input  logic [NUM_PROC-1:0]       req_kind_in,
    input  logic [NUM_PROC*32-1:0]    req_addr_in,
    output logic [NUM_PROC-1:0]       req_ready_out,
    output logic [NUM_PROC-1:0]       resp_valid_out,
    output logic [NUM_PROC*32-1:0]    resp_data_out,
    output logic [32+PROC_BITS-1:0]   idx_addr_out,
    output logic                      idx_valid_out,
    output logic [32+PROC_BITS-1:0]   data_addra_out,
    output logic                      data_validina_out,
    output logic [32+PROC_BITS-1:0]   data_addrb_out,
    output logic                      data_validinb_out,
    input  logic [31:0]               rowidx_in,
    input  logic [31:0]               data_ina,
    input  logic [31:0]               data_inb,
    output logic                      busy_out
);

    localparam int unsigned AddrW    = 32 + PROC_BITS;
    localparam int unsigned Depth    = MEM_LATENCY + 1;
    localparam int unsigned NumPorts = 3;

    typedef logic [PROC_BITS-1:0] proc_id_t;

    function automatic proc_id_t wrap_add(input proc_id_t base, input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_PROC) begin
            sum = sum - NUM_PROC;
        end
        return proc_id_t'(sum);
    endfunction

    logic [NUM_PROC-1:0] idx_cand;
    logic [NUM_PROC-1:0] data_cand;
    logic                idx_gnt;
    logic                a_gnt;
    logic                b_gnt;
    proc_id_t            idx_id;
    proc_id_t            a_id;
    proc_id_t            b_id;
    proc_id_t            idx_ptr_q;
    proc_id_t            idx_ptr_d;
    proc_id_t            data_ptr_q;
    proc_id_t            data_ptr_d;

    assign idx_cand  = req_valid_in & ~req_kind_in;
    assign data_cand = req_valid_in & req_kind_in;

    // Cyclic first-match searches; B starts just past A's grantee so it never picks A's owner.
    always_comb begin
        proc_id_t cand;
        cand    = '0;
        idx_gnt = 1'b0;
        idx_id  = '0;
        a_gnt   = 1'b0;
        a_id    = '0;
        b_gnt   = 1'b0;
        b_id    = '0;
        for (int unsigned off = 0; off < NUM_PROC; off++) begin
            cand = wrap_add(idx_ptr_q, off);
            if (!idx_gnt && idx_cand[cand]) begin
                idx_gnt = 1'b1;
                idx_id  = cand;
            end
        end
        for (int unsigned off = 0; off < NUM_PROC; off++) begin
            cand = wrap_add(data_ptr_q, off);
            if (!a_gnt && data_cand[cand]) begin
                a_gnt = 1'b1;
                a_id  = cand;
            end
        end
        for (int unsigned off = 1; off < NUM_PROC; off++) begin
            cand = wrap_add(a_id, off);
            if (a_gnt && !b_gnt && data_cand[cand]) begin
                b_gnt = 1'b1;
                b_id  = cand;
            end
        end
    end

    always_comb begin
        idx_ptr_d  = idx_gnt ? wrap_add(idx_id, 1) : idx_ptr_q;
        data_ptr_d = data_ptr_q;
        if (b_gnt) begin
            data_ptr_d = wrap_add(b_id, 1);
        end else if (a_gnt) begin
            data_ptr_d = wrap_add(a_id, 1);
        end
    end

    // Grants are combinational, so reset must mask them directly to clear immediately.
    always_comb begin
        req_ready_out = '0;
        if (!rst_in) begin
            if (idx_gnt) req_ready_out[idx_id] = 1'b1;
            if (a_gnt)   req_ready_out[a_id]   = 1'b1;
            if (b_gnt)   req_ready_out[b_id]   = 1'b1;
        end
    end

    logic     [NumPorts-1:0]            port_gnt;
    proc_id_t [NumPorts-1:0]            port_id;
    logic     [NumPorts-1:0][31:0]      port_addr;
    logic     [NumPorts-1:0][31:0]      port_rdata;

    assign port_gnt   = {b_gnt, a_gnt, idx_gnt};
    assign port_id    = {b_id, a_id, idx_id};
    assign port_rdata = {data_inb, data_ina, rowidx_in};

    always_comb begin
        port_addr = '0;
        for (int unsigned p = 0; p < NumPorts; p++) begin
            for (int unsigned i = 0; i < NUM_PROC; i++) begin
                if (port_id[p] == proc_id_t'(i)) begin
                    port_addr[p] = req_addr_in[32*i +: 32];
                end
            end
        end
    end

    logic     [NumPorts-1:0][AddrW-1:0]          addr_q;
    logic     [NumPorts-1:0][Depth-1:0]          tag_vld_q;
    proc_id_t [NumPorts-1:0][Depth-1:0]          tag_id_q;
    logic     [NUM_PROC-1:0]                     resp_valid_q;
    logic     [NUM_PROC-1:0]                     resp_valid_d;
    logic     [NUM_PROC*32-1:0]                  resp_data_q;
    logic     [NUM_PROC*32-1:0]                  resp_data_d;

    // Tag stage 0 doubles as the port's issue strobe.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            idx_ptr_q    <= '0;
            data_ptr_q   <= '0;
            addr_q       <= '0;
            tag_vld_q    <= '0;
            tag_id_q     <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            idx_ptr_q    <= idx_ptr_d;
            data_ptr_q   <= data_ptr_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            for (int unsigned p = 0; p < NumPorts; p++) begin
                if (port_gnt[p]) begin
                    addr_q[p] <= {port_id[p], port_addr[p]};
                end
                tag_vld_q[p][0] <= port_gnt[p];
                tag_id_q[p][0]  <= port_id[p];
                for (int unsigned s = 1; s < Depth; s++) begin
                    tag_vld_q[p][s] <= tag_vld_q[p][s-1];
                    tag_id_q[p][s]  <= tag_id_q[p][s-1];
                end
            end
        end
    end

    // All ports share one latency, so tags retiring together belong to distinct processors.
    always_comb begin
        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        for (int unsigned p = 0; p < NumPorts; p++) begin
            if (tag_vld_q[p][Depth-1]) begin
                for (int unsigned i = 0; i < NUM_PROC; i++) begin
                    if (tag_id_q[p][Depth-1] == proc_id_t'(i)) begin
                        resp_valid_d[i]          = 1'b1;
                        resp_data_d[32*i +: 32]  = port_rdata[p];
                    end
                end
            end
        end
    end

    always_comb begin
        busy_out = 1'b0;
        for (int unsigned p = 0; p < NumPorts; p++) begin
            busy_out = busy_out | (|tag_vld_q[p]);
        end
    end

    assign idx_addr_out      = addr_q[0];
    assign idx_valid_out     = tag_vld_q[0][0];
    assign data_addra_out    = addr_q[1];
    assign data_validina_out = tag_vld_q[1][0];
    assign data_addrb_out    = addr_q[2];
    assign data_validinb_out = tag_vld_q[2][0];
    assign resp_valid_out    = resp_valid_q;
    assign resp_data_out     = resp_data_q;

endmodule

// File: tb/tb_graph_mem_arbiter.sv
// Scoreboard bench for graph_mem_arbiter: a rule-level arbitration model predicts grants and
// responses, a BRAM model answers issued reads, and a monitor checks every response strobe.
module tb_graph_mem_arbiter;

    localparam int NP = 4;

    typedef struct {
        logic        kind;
        logic [31:0] addr;
    } req_t;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_in = 1'b1;
    logic [NP-1:0]      req_valid_in;
    logic [NP-1:0]      req_kind_in;
    logic [NP*32-1:0]   req_addr_in;
    logic [NP-1:0]      req_ready_out;
    logic [NP-1:0]      resp_valid_out;
    logic [NP*32-1:0]   resp_data_out;
    logic [33:0]        idx_addr_out;
    logic               idx_valid_out;
    logic [33:0]        data_addra_out;
    logic               data_validina_out;
    logic [33:0]        data_addrb_out;
    logic               data_validinb_out;
    logic [31:0]        rowidx_in;
    logic [31:0]        data_ina;
    logic [31:0]        data_inb;
    logic               busy_out;

    graph_mem_arbiter #(
        .NUM_PROC   (NP),
        .PROC_BITS  (2),
        .MEM_LATENCY(2)
    ) dut (
        .clk_in           (clk),
        .rst_in           (rst_in),
        .req_valid_in     (req_valid_in),
        .req_kind_in      (req_kind_in),
        .req_addr_in      (req_addr_in),
        .req_ready_out    (req_ready_out),
        .resp_valid_out   (resp_valid_out),
        .resp_data_out    (resp_data_out),
        .idx_addr_out     (idx_addr_out),
        .idx_valid_out    (idx_valid_out),
        .data_addra_out   (data_addra_out),
        .data_validina_out(data_validina_out),
        .data_addrb_out   (data_addrb_out),
        .data_validinb_out(data_validinb_out),
        .rowidx_in        (rowidx_in),
        .data_ina         (data_ina),
        .data_inb         (data_inb),
        .busy_out         (busy_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    req_t        req_q [NP][$];
    exp_t        sb    [NP][$];
    int          idx_ptr_m;
    int          data_ptr_m;
    int          wait_c [NP];
    logic        exp_v  [3];
    logic [33:0] exp_a  [3];
    logic [2:0]  hist;
    bit          rand_mode = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Memory contents depend on port and tagged address, so a wrong port, tag or address shows.
    function automatic logic [31:0] mem_word(input int p, input logic [33:0] ta);
        logic [31:0] salt;
        salt = 32'(p + 1) * 32'h0101_0101;
        return (ta[31:0] * 32'h9E37_79B1) ^ salt ^ {ta[33:32], 30'h0};
    endfunction

    function automatic logic port_valid(input int p);
        case (p)
            0:       return idx_valid_out;
            1:       return data_validina_out;
            default: return data_validinb_out;
        endcase
    endfunction

    function automatic logic [33:0] port_addr(input int p);
        case (p)
            0:       return idx_addr_out;
            1:       return data_addra_out;
            default: return data_addrb_out;
        endcase
    endfunction

    // BRAM model: address seen in the cycle after issue, data on the port two cycles later.
    logic        mh_v [3][3];
    logic [33:0] mh_a [3][3];
    initial begin
        for (int p = 0; p < 3; p++) begin
            for (int s = 0; s < 3; s++) begin
                mh_v[p][s] = 1'b0;
                mh_a[p][s] = '0;
            end
        end
        rowidx_in = '0;
        data_ina  = '0;
        data_inb  = '0;
        forever begin
            @(negedge clk);
            for (int p = 0; p < 3; p++) begin
                mh_v[p][2] = mh_v[p][1];
                mh_a[p][2] = mh_a[p][1];
                mh_v[p][1] = mh_v[p][0];
                mh_a[p][1] = mh_a[p][0];
                mh_v[p][0] = port_valid(p);
                mh_a[p][0] = port_addr(p);
            end
            rowidx_in = mh_v[0][2] ? mem_word(0, mh_a[0][2]) : $urandom();
            data_ina  = mh_v[1][2] ? mem_word(1, mh_a[1][2]) : $urandom();
            data_inb  = mh_v[2][2] ? mem_word(2, mh_a[2][2]) : $urandom();
        end
    end

    // Response monitor: every strobe must match the oldest expectation for its lane.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NP; i++) begin
                if (resp_valid_out[i]) begin
                    if (sb[i].size() == 0) begin
                        check("resp_unexpected", 64'(resp_valid_out[i]), 64'(0));
                    end else begin
                        e = sb[i].pop_front();
                        check("resp_data", 64'(resp_data_out[32*i +: 32]), 64'(e.data));
                        check("resp_cycle", 64'(cyc), 64'(e.due));
                    end
                end else if (sb[i].size() != 0 && sb[i][0].due <= cyc) begin
                    e = sb[i].pop_front();
                    check("resp_missing", 64'(resp_valid_out[i]), 64'(1));
                end
            end
        end
    end

    function automatic int first_from(input int start, input int first_off, input logic kind);
        for (int o = first_off; o < NP; o++) begin
            int j;
            j = (start + o) % NP;
            if (req_valid_in[j] && req_kind_in[j] == kind) return j;
        end
        return -1;
    endfunction

    function automatic bit any_pending();
        bit pend;
        pend = (hist != 0);
        for (int i = 0; i < NP; i++) begin
            if (req_q[i].size() != 0 || sb[i].size() != 0) pend = 1'b1;
        end
        return pend;
    endfunction

    task automatic drive();
        for (int i = 0; i < NP; i++) begin
            if (req_q[i].size() != 0) begin
                req_valid_in[i]          = 1'b1;
                req_kind_in[i]           = req_q[i][0].kind;
                req_addr_in[32*i +: 32]  = req_q[i][0].addr;
            end else begin
                req_valid_in[i]          = 1'b0;
                req_kind_in[i]           = 1'($urandom());
                req_addr_in[32*i +: 32]  = $urandom();
            end
        end
    endtask

    task automatic push(input int i, input logic kind, input logic [31:0] addr);
        req_t r;
        r.kind = kind;
        r.addr = addr;
        req_q[i].push_back(r);
    endtask

    task automatic clear_model();
        for (int i = 0; i < NP; i++) begin
            req_q[i].delete();
            sb[i].delete();
            wait_c[i] = 0;
        end
        for (int p = 0; p < 3; p++) begin
            exp_v[p] = 1'b0;
            exp_a[p] = '0;
        end
        idx_ptr_m  = 0;
        data_ptr_m = 0;
        hist       = '0;
    endtask

    // One clock: check issue/busy/grants at the negedge, then advance requests after the edge.
    task automatic model_step();
        int          g [3];
        logic [NP-1:0] exp_rdy;
        logic [1:0]  idb;
        exp_t        e;
        string       pname [3];
        pname = '{"idx_issue", "a_issue", "b_issue"};
        @(negedge clk);
        for (int p = 0; p < 3; p++) begin
            check(pname[p], 64'({port_valid(p), port_addr(p)}), 64'({exp_v[p], exp_a[p]}));
        end
        check("busy", 64'(busy_out), 64'(hist != 0));
        g[0] = first_from(idx_ptr_m, 0, 1'b0);
        g[1] = first_from(data_ptr_m, 0, 1'b1);
        g[2] = (g[1] >= 0) ? first_from(g[1], 1, 1'b1) : -1;
        exp_rdy = '0;
        for (int p = 0; p < 3; p++) begin
            if (g[p] >= 0) exp_rdy[g[p]] = 1'b1;
        end
        check("ready", 64'(req_ready_out), 64'(exp_rdy));
        for (int p = 0; p < 3; p++) begin
            if (g[p] >= 0) begin
                idb      = 2'(g[p]);
                exp_v[p] = 1'b1;
                exp_a[p] = {idb, req_q[g[p]][0].addr};
                e.data   = mem_word(p, exp_a[p]);
                e.due    = cyc + 4;
                sb[g[p]].push_back(e);
                check("starve", 64'(wait_c[g[p]] < NP), 64'(1));
                wait_c[g[p]] = 0;
                void'(req_q[g[p]].pop_front());
            end else begin
                exp_v[p] = 1'b0;
            end
        end
        for (int i = 0; i < NP; i++) begin
            if (req_valid_in[i] && !exp_rdy[i]) wait_c[i]++;
        end
        hist = {hist[1:0], |exp_rdy};
        if (g[0] >= 0) idx_ptr_m = (g[0] + 1) % NP;
        if (g[2] >= 0) data_ptr_m = (g[2] + 1) % NP;
        else if (g[1] >= 0) data_ptr_m = (g[1] + 1) % NP;
        @(posedge clk);
        #1;
        if (rand_mode) begin
            for (int i = 0; i < NP; i++) begin
                if (req_q[i].size() == 0 && $urandom_range(1, 0) == 1) begin
                    push(i, 1'($urandom()), $urandom());
                end
            end
        end
        drive();
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while (any_pending() && n < budget) begin
            model_step();
            n++;
        end
        check("drain", 64'(any_pending()), 64'(0));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ready"}, 64'(req_ready_out), 64'(0));
        check({tag, "_resp_valid"}, 64'(resp_valid_out), 64'(0));
        check({tag, "_valids"},
              64'({busy_out, idx_valid_out, data_validina_out, data_validinb_out}), 64'(0));
        check({tag, "_idx_addr"}, 64'(idx_addr_out), 64'(0));
        check({tag, "_a_addr"}, 64'(data_addra_out), 64'(0));
        check({tag, "_b_addr"}, 64'(data_addrb_out), 64'(0));
        check({tag, "_resp_data"}, 64'(resp_data_out != '0), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish before 500000");
        $fatal(1);
    end

    initial begin
        req_valid_in = '0;
        req_kind_in  = '0;
        req_addr_in  = '0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        check_zero("por");
        rst_in = 1'b0;

        // Single row-pointer read from proc 2.
        push(2, 1'b0, 32'd5);
        drive();
        run_until_idle(20);

        // All processors stream data reads: A/B pairs rotate (0,1), (2,3).
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NP; i++) push(i, 1'b1, 32'h100 + 32'(16 * i + r));
        end
        drive();
        run_until_idle(60);

        // Three ports granted in one cycle, proc 3 waits a cycle.
        push(0, 1'b0, 32'd7);
        push(1, 1'b1, 32'd8);
        push(2, 1'b1, 32'd9);
        push(3, 1'b1, 32'd10);
        drive();
        run_until_idle(20);

        // Lone data requester: port A every cycle, port B idle.
        for (int r = 0; r < 4; r++) push(3, 1'b1, 32'h200 + 32'(r));
        drive();
        run_until_idle(20);

        // Proc 1 competes with a continuous idx stream from 0, 2 and 3.
        push(1, 1'b0, 32'h300);
        for (int r = 0; r < 6; r++) begin
            push(0, 1'b0, 32'h310 + 32'(r));
            push(2, 1'b0, 32'h320 + 32'(r));
            push(3, 1'b0, 32'h330 + 32'(r));
        end
        drive();
        run_until_idle(60);

        // Reset mid-cycle with reads in flight and a request still held.
        push(0, 1'b1, 32'h400);
        push(1, 1'b1, 32'h401);
        for (int r = 0; r < 3; r++) push(2, 1'b0, 32'h500 + 32'(r));
        drive();
        model_step();
        model_step();
        #1;
        rst_in = 1'b1;
        #1;
        check_zero("rst_async");
        clear_model();
        drive();
        @(negedge clk);
        check_zero("rst_hold");
        @(posedge clk);
        #1;
        rst_in = 1'b0;

        // Pointers restart at 0: first data pair must be (0,1).
        for (int i = 0; i < NP; i++) push(i, 1'b1, 32'h600 + 32'(i));
        drive();
        run_until_idle(60);

        rand_mode = 1'b1;
        repeat (400) model_step();
        rand_mode = 1'b0;
        run_until_idle(100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
